dkong_rom_loader: RTL and testbench

- Sits between the HPS ioctl download stream and the core's ROM dprams, DIP/mod registers and core reset.
- Decodes each download byte by index and address.
- Generates registered write strobes for the CPU, sound and wave ROM dprams.
- Captures the mod byte and DIP bytes, keeps a running checksum and byte count, and holds the core in reset until the ROM set is loaded and a settle delay has elapsed.

---
 rtl/dkong_rom_loader.sv | 130 +++++++++++++
 tb/tb_dkong_rom_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dkong_rom_loader.sv
// dkong_rom_loader: routes ioctl download bytes to ROM dprams, DIP/mod registers, and gates core reset.
module dkong_rom_loader #(
    parameter logic [24:0] CPU_END     = 25'h08000,
    parameter logic [24:0] SND_BASE    = 25'h0E000,
    parameter logic [24:0] SND_END     = 25'h0F000,
    parameter logic [24:0] WAV_BASE    = 25'h10000,
    parameter int          HOLD_CYCLES = 256
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        cpu_we,
    output logic        snd_we,
    output logic        wav_we,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [7:0]  mod,
    output logic [63:0] dip_sw,
    output logic [15:0] checksum,
    output logic [24:0] byte_count,
    output logic        rom_ready,
    output logic        core_reset
);
    localparam logic [24:0] WAV_END = WAV_BASE + 25'h10000;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, READY} state_t;

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        dl_prev_q, loaded_q, loaded_d;
    logic        cpu_we_q, cpu_we_d, snd_we_q, snd_we_d, wav_we_q, wav_we_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d, mod_q, mod_d;
    logic [63:0] dip_q, dip_d;
    logic [15:0] checksum_q, checksum_d, cs_base;
    logic [24:0] byte_count_q, byte_count_d, bc_base;
    logic        rom_ready_q, rom_ready_d, core_reset_q, core_reset_d;
    logic        start, fall, wr, idx0, rom_wr, clr;

    always_comb begin
        start        = ioctl_download & ~dl_prev_q;
        fall         = ~ioctl_download & dl_prev_q;
        wr           = ioctl_wr & ioctl_download;
        idx0         = ioctl_index == 8'd0;
        rom_wr       = wr & idx0;
        clr          = start & idx0;
        cpu_we_d     = rom_wr && ioctl_addr < CPU_END;
        snd_we_d     = rom_wr && ioctl_addr >= SND_BASE && ioctl_addr < SND_END;
        wav_we_d     = rom_wr && ioctl_addr >= WAV_BASE && ioctl_addr < WAV_END;
        wr_addr_d    = cpu_we_d ? ioctl_addr[15:0] :
                       snd_we_d ? ioctl_addr[15:0] - SND_BASE[15:0] :
                       wav_we_d ? ioctl_addr[15:0] - WAV_BASE[15:0] : wr_addr_q;
        wr_data_d    = (cpu_we_d | snd_we_d | wav_we_d) ? ioctl_dout : wr_data_q;
        mod_d        = (wr && ioctl_index == 8'd1 && ioctl_addr == 25'd0) ? ioctl_dout : mod_q;
        dip_d        = dip_q;
        if (wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == 22'd0)
            dip_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
        // A start coinciding with a strobe clears first, then accumulates that byte.
        cs_base      = clr ? 16'd0 : checksum_q;
        checksum_d   = cs_base + (rom_wr ? {8'd0, ioctl_dout} : 16'd0);
        bc_base      = clr ? 25'd0 : byte_count_q;
        byte_count_d = (rom_wr && ~&bc_base) ? bc_base + 25'd1 : bc_base;
        loaded_d     = clr ? 1'b0 : (state_q == LOAD && fall && idx0) ? 1'b1 : loaded_q;
        state_d      = state_q;
        hold_d       = hold_q;
        if (start) begin
            state_d = LOAD;
        end else if (state_q == LOAD && fall) begin
            state_d = HOLD;
            hold_d  = 16'(HOLD_CYCLES - 1);
        end else if (state_q == HOLD) begin
            state_d = hold_q == 16'd0 ? (loaded_q ? READY : IDLE) : HOLD;
            hold_d  = hold_q == 16'd0 ? hold_q : hold_q - 16'd1;
        end
        rom_ready_d  = state_d == READY;
        core_reset_d = state_d != READY;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            dl_prev_q    <= 1'b1;
            loaded_q     <= 1'b0;
            cpu_we_q     <= 1'b0;
            snd_we_q     <= 1'b0;
            wav_we_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            mod_q        <= '0;
            dip_q        <= '0;
            checksum_q   <= '0;
            byte_count_q <= '0;
            rom_ready_q  <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            dl_prev_q    <= ioctl_download;
            loaded_q     <= loaded_d;
            cpu_we_q     <= cpu_we_d;
            snd_we_q     <= snd_we_d;
            wav_we_q     <= wav_we_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            mod_q        <= mod_d;
            dip_q        <= dip_d;
            checksum_q   <= checksum_d;
            byte_count_q <= byte_count_d;
            rom_ready_q  <= rom_ready_d;
            core_reset_q <= core_reset_d;
        end
    end

    assign cpu_we     = cpu_we_q;
    assign snd_we     = snd_we_q;
    assign wav_we     = wav_we_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign mod        = mod_q;
    assign dip_sw     = dip_q;
    assign checksum   = checksum_q;
    assign byte_count = byte_count_q;
    assign rom_ready  = rom_ready_q;
    assign core_reset = core_reset_q;
endmodule

// File: tb/tb_dkong_rom_loader.sv
// tb_dkong_rom_loader: table-driven and randomized checks against a transaction-level model.
module tb_dkong_rom_loader;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        cpu_we, snd_we, wav_we, rom_ready, core_reset;
    logic [15:0] wr_addr, checksum;
    logic [7:0]  wr_data, mod;
    logic [63:0] dip_sw;
    logic [24:0] byte_count;

    dkong_rom_loader dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .cpu_we(cpu_we), .snd_we(snd_we), .wav_we(wav_we),
        .wr_addr(wr_addr), .wr_data(wr_data), .mod(mod), .dip_sw(dip_sw),
        .checksum(checksum), .byte_count(byte_count), .rom_ready(rom_ready),
        .core_reset(core_reset)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [2:0]  we;
        logic [15:0] waddr;
    } vec_t;

    vec_t        vec [18];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] m_sum;
    int          m_cnt;
    logic [15:0] last_addr;
    logic [7:0]  last_data;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void route(input logic [24:0] a, output logic [2:0] we, output logic [15:0] wa);
        int ai = int'(a);
        we = 3'b000;
        wa = 16'd0;
        if (ai < 'h8000) begin
            we = 3'b100; wa = 16'(ai);
        end else if (ai >= 'hE000 && ai < 'hF000) begin
            we = 3'b010; wa = 16'(ai - 'hE000);
        end else if (ai >= 'h10000 && ai < 'h20000) begin
            we = 3'b001; wa = 16'(ai - 'h10000);
        end
    endfunction

    task automatic send(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    task automatic rom_byte(input logic [24:0] a, input logic [7:0] d, input logic [2:0] we, input logic [15:0] wa);
        send(8'd0, a, d);
        if (we != 3'b000) begin
            last_addr = wa;
            last_data = d;
        end
        m_sum = m_sum + 16'(d);
        m_cnt++;
        check("strobe", 64'({cpu_we, snd_we, wav_we}), 64'(we));
        check("wr_addr", 64'(wr_addr), 64'(last_addr));
        check("wr_data", 64'(wr_data), 64'(last_data));
        check("checksum", 64'(checksum), 64'(m_sum));
        check("byte_count", 64'(byte_count), 64'(m_cnt));
        tick();
        check("strobe_drop", 64'({cpu_we, snd_we, wav_we}), 64'd0);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        if (idx == 8'd0) begin
            m_sum = 16'd0;
            m_cnt = 0;
        end
        tick();
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic hold_check(input logic exp_ready);
        logic ok = 1'b1;
        repeat (255) begin
            tick();
            if (!core_reset || rom_ready) ok = 1'b0;
        end
        check("hold_in_reset", 64'(ok), 64'd1);
        tick();
        check("rom_ready_after_hold", 64'(rom_ready), 64'(exp_ready));
        check("core_reset_after_hold", 64'(core_reset), 64'(!exp_ready));
    endtask

    task automatic check_reset_vals();
        check("rst_we", 64'({cpu_we, snd_we, wav_we}), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_mod", 64'(mod), 64'd0);
        check("rst_dip", dip_sw, 64'd0);
        check("rst_checksum", 64'(checksum), 64'd0);
        check("rst_byte_count", 64'(byte_count), 64'd0);
        check("rst_rom_ready", 64'(rom_ready), 64'd0);
        check("rst_core_reset", 64'(core_reset), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        check_reset_vals();
        reset = 1'b0;
        m_sum = 16'd0;
        m_cnt = 0;
        last_addr = 16'd0;
        last_data = 8'd0;
    endtask

    initial begin
        logic [2:0]  we;
        logic [15:0] wa;
        logic        ok;
        vec[0]  = '{25'h0000000, 8'h01, 3'b100, 16'h0000};
        vec[1]  = '{25'h0000001, 8'h02, 3'b100, 16'h0001};
        vec[2]  = '{25'h0000002, 8'h03, 3'b100, 16'h0002};
        vec[3]  = '{25'h0000003, 8'h04, 3'b100, 16'h0003};
        vec[4]  = '{25'h0007FFF, 8'h11, 3'b100, 16'h7FFF};
        vec[5]  = '{25'h0008000, 8'h22, 3'b000, 16'h0000};
        vec[6]  = '{25'h000DFFF, 8'h33, 3'b000, 16'h0000};
        vec[7]  = '{25'h000E000, 8'h44, 3'b010, 16'h0000};
        vec[8]  = '{25'h000EFFF, 8'h55, 3'b010, 16'h0FFF};
        vec[9]  = '{25'h000F000, 8'h66, 3'b000, 16'h0000};
        vec[10] = '{25'h000FFFF, 8'h77, 3'b000, 16'h0000};
        vec[11] = '{25'h0010000, 8'h88, 3'b001, 16'h0000};
        vec[12] = '{25'h001FFFF, 8'h99, 3'b001, 16'hFFFF};
        vec[13] = '{25'h0020000, 8'hAB, 3'b000, 16'h0000};
        vec[14] = '{25'h000E005, 8'hAA, 3'b010, 16'h0005};
        vec[15] = '{25'h0010010, 8'h55, 3'b001, 16'h0010};
        vec[16] = '{25'h0009000, 8'hC3, 3'b000, 16'h0000};
        vec[17] = '{25'h1FFFFFF, 8'h5A, 3'b000, 16'h0000};

        do_reset();
        tick();

        start_dl(8'd0);
        for (int i = 0; i < 4; i++) rom_byte(vec[i].addr, vec[i].data, vec[i].we, vec[i].waddr);
        check("t1_checksum", 64'(checksum), 64'h000A);
        check("t1_count", 64'(byte_count), 64'd4);
        end_dl();
        check("t1_fall_reset", 64'(core_reset), 64'd1);
        hold_check(1'b1);

        start_dl(8'd0);
        check("t2_start_clear", 64'({checksum, 7'd0, byte_count}), 64'd0);
        check("t2_start_core_reset", 64'(core_reset), 64'd1);
        for (int i = 4; i < 18; i++) rom_byte(vec[i].addr, vec[i].data, vec[i].we, vec[i].waddr);
        end_dl();
        hold_check(1'b1);

        start_dl(8'd254);
        check("t3_dip_core_reset", 64'(core_reset), 64'd1);
        send(8'd254, 25'd0, 8'h80);
        send(8'd254, 25'd7, 8'h0F);
        send(8'd254, 25'd8, 8'hFF);
        check("t3_no_strobe", 64'({cpu_we, snd_we, wav_we}), 64'd0);
        end_dl();
        hold_check(1'b1);
        check("t3_dip", dip_sw, 64'h0F00_0000_0000_0080);
        check("t3_checksum_kept", 64'(checksum), 64'(m_sum));
        check("t3_count_kept", 64'(byte_count), 64'(m_cnt));

        start_dl(8'd0);
        for (int i = 0; i < 200; i++) begin
            logic [24:0] a;
            a = ($urandom_range(0, 3) == 0) ? 25'($urandom) : 25'($urandom_range(0, 'h2FFFF));
            route(a, we, wa);
            rom_byte(a, 8'($urandom), we, wa);
            repeat ($urandom_range(0, 2)) tick();
        end
        end_dl();
        hold_check(1'b1);

        start_dl(8'd0);
        rom_byte(25'd5, 8'h21, 3'b100, 16'd5);
        end_dl();
        repeat (100) tick();
        ioctl_index    = 8'd0;
        ioctl_addr     = 25'd2;
        ioctl_dout     = 8'h3C;
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        m_sum = 16'h003C;
        m_cnt = 1;
        check("t5_sim_checksum", 64'(checksum), 64'h003C);
        check("t5_sim_count", 64'(byte_count), 64'd1);
        check("t5_sim_strobe", 64'({cpu_we, wr_addr, wr_data}), 64'({1'b1, 16'd2, 8'h3C}));
        tick();
        end_dl();
        hold_check(1'b1);

        do_reset();
        start_dl(8'd1);
        send(8'd1, 25'd0, 8'h04);
        check("t4_no_strobe", 64'({cpu_we, snd_we, wav_we}), 64'd0);
        send(8'd1, 25'd1, 8'h99);
        check("t4_mod", 64'(mod), 64'h04);
        end_dl();
        hold_check(1'b0);
        check("t4_checksum", 64'(checksum), 64'd0);

        start_dl(8'd0);
        rom_byte(25'h10, 8'h77, 3'b100, 16'h10);
        do_reset();
        rom_byte(25'hE001, 8'h12, 3'b010, 16'h0001);
        end_dl();
        ok = 1'b1;
        repeat (300) begin
            tick();
            if (rom_ready || !core_reset) ok = 1'b0;
        end
        check("t6_stays_idle", 64'(ok), 64'd1);
        start_dl(8'd0);
        end_dl();
        hold_check(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
